// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the fetch PC and sequences it through linear flow,
// jumps, calls and returns. Drives push/pop strobes of the external 16-slot
// PC stack and tracks call depth, since the stack cannot detect over/underflow.
module pc_sequencer #(
   parameter int              AW       = 11,
   parameter int              DEPTH    = 15,
   parameter logic [AW-1:0]   RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          op_jmp,
   input  logic          op_call,
   input  logic          op_ret,
   input  logic          cond_ok,
   input  logic [AW-1:0] target,
   output logic [AW-1:0] pc,
   output logic          pc_valid,
   output logic          stack_wr_en,
   output logic          stack_rd_en,
   output logic [AW-1:0] stack_din,
   input  logic [AW-1:0] stack_dout,
   output logic [3:0]    depth,
   output logic          fault,
   output logic [1:0]    fault_code
);

   localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);
   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_OVF  = 2'b01;
   localparam logic [1:0] CODE_UNF  = 2'b10;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_RET_LOAD = 2'd1,
      S_FAULT    = 2'd2
   } state_t;

   state_t        state_q;
   logic [AW-1:0] pc_q;
   logic          pc_valid_q;
   logic [3:0]    depth_q;
   logic          fault_q;
   logic [1:0]    fault_code_q;

   logic [AW-1:0] pc_inc_d;
   logic          advance;
   logic          take_jmp;
   logic          take_call;
   logic          take_ret;
   logic          can_push;
   logic          can_pop;

   // Decode the prioritised op (ret > call > jmp) and derive the stack strobes.
   always_comb begin
      pc_inc_d    = pc_q + AW'(1);
      advance     = (state_q == S_RUN) && en;
      take_ret    = advance && cond_ok && op_ret;
      take_call   = advance && cond_ok && op_call && !op_ret;
      take_jmp    = advance && cond_ok && op_jmp && !op_call && !op_ret;
      can_push    = depth_q < DEPTH_MAX;
      can_pop     = depth_q != 4'd0;
      stack_wr_en = take_call && can_push;
      stack_rd_en = take_ret && can_pop;
   end

   // Sequencer FSM: PC, call depth and sticky fault all update here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_RUN;
         pc_q         <= RESET_PC;
         pc_valid_q   <= 1'b1;
         depth_q      <= 4'd0;
         fault_q      <= 1'b0;
         fault_code_q <= CODE_NONE;
      end else begin
         case (state_q)
            S_RUN: begin
               if (en) begin
                  if (take_ret) begin
                     // PC holds while the popped address is fetched from the stack.
                     pc_valid_q <= 1'b0;
                     if (can_pop) begin
                        depth_q <= depth_q - 4'd1;
                        state_q <= S_RET_LOAD;
                     end else begin
                        fault_q      <= 1'b1;
                        fault_code_q <= CODE_UNF;
                        state_q      <= S_FAULT;
                     end
                  end else if (take_call) begin
                     if (can_push) begin
                        pc_q    <= target;
                        depth_q <= depth_q + 4'd1;
                     end else begin
                        pc_valid_q   <= 1'b0;
                        fault_q      <= 1'b1;
                        fault_code_q <= CODE_OVF;
                        state_q      <= S_FAULT;
                     end
                  end else if (take_jmp) begin
                     pc_q <= target;
                  end else begin
                     pc_q <= pc_inc_d;
                  end
               end
            end
            S_RET_LOAD: begin
               pc_q       <= stack_dout;
               pc_valid_q <= 1'b1;
               state_q    <= S_RUN;
            end
            S_FAULT: begin
               pc_valid_q <= 1'b0;
            end
            default: begin
               pc_valid_q <= 1'b0;
               state_q    <= S_FAULT;
            end
         endcase
      end
   end

   assign pc         = pc_q;
   assign pc_valid   = pc_valid_q;
   assign stack_din  = pc_inc_d;
   assign depth      = depth_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed stimulus pushes hand-computed expected
// outputs into a scoreboard queue; a monitor compares each cycle's outputs.
module tb_pc_sequencer;

   localparam int AW = 11;

   // {en, op_jmp, op_call, op_ret, cond_ok}
   localparam logic [4:0] NOP    = 5'b10000;
   localparam logic [4:0] JMP    = 5'b11001;
   localparam logic [4:0] JMP_NC = 5'b11000;
   localparam logic [4:0] CALL   = 5'b10101;
   localparam logic [4:0] RET    = 5'b10011;
   localparam logic [4:0] ALL3   = 5'b11111;
   localparam logic [4:0] CJ     = 5'b11101;
   localparam logic [4:0] CR     = 5'b10111;
   localparam logic [4:0] STALLC = 5'b00101;
   localparam logic [4:0] IDLE   = 5'b00000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en, op_jmp, op_call, op_ret, cond_ok;
   logic [AW-1:0] target;
   logic [AW-1:0] pc;
   logic          pc_valid;
   logic          stack_wr_en, stack_rd_en;
   logic [AW-1:0] stack_din;
   logic [AW-1:0] stack_dout;
   logic [3:0]    depth;
   logic          fault;
   logic [1:0]    fault_code;

   always #5 clk = ~clk;

   pc_sequencer #(.AW(AW), .DEPTH(15), .RESET_PC(11'h000)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .op_jmp     (op_jmp),
      .op_call    (op_call),
      .op_ret     (op_ret),
      .cond_ok    (cond_ok),
      .target     (target),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .stack_wr_en(stack_wr_en),
      .stack_rd_en(stack_rd_en),
      .stack_din  (stack_din),
      .stack_dout (stack_dout),
      .depth      (depth),
      .fault      (fault),
      .fault_code (fault_code)
   );

   // Behavioural 16-slot PC stack; popped value appears the cycle after the pop.
   logic [AW-1:0] smem [16];
   logic [3:0]    sp;
   always @(posedge clk) begin
      if (rst) begin
         sp <= 4'd0;
      end else if (stack_wr_en) begin
         smem[sp] <= stack_din;
         sp       <= sp + 4'd1;
      end else if (stack_rd_en) begin
         stack_dout <= smem[sp - 4'd1];
         sp         <= sp - 4'd1;
      end
   end

   logic [31:0] exp_q [$];
   string       name_q [$];
   int          checks = 0;
   int          fails  = 0;

   // Monitor: compare the outputs of every cycle that has a queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() != 0) begin : cmp
            logic [31:0] e;
            logic [31:0] a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {pc, pc_valid, stack_wr_en, stack_rd_en, stack_din, depth, fault, fault_code};
            checks++;
            if (a !== e) begin
               fails++;
               $display("FAIL %s: got pc=%h v=%b wr=%b rd=%b din=%h dep=%0d f=%b code=%b ; want pc=%h v=%b wr=%b rd=%b din=%h dep=%0d f=%b code=%b",
                        n, a[31:21], a[20], a[19], a[18], a[17:7], a[6:3], a[2], a[1:0],
                        e[31:21], e[20], e[19], e[18], e[17:7], e[6:3], e[2], e[1:0]);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      {en, op_jmp, op_call, op_ret, cond_ok} = IDLE;
      target = '0;
   endtask

   task automatic cyc(input string nm, input logic [4:0] ctl, input logic [AW-1:0] tgt,
                      input logic [AW-1:0] e_pc, input logic e_v, input logic e_wr,
                      input logic e_rd, input logic [3:0] e_dep, input logic e_f,
                      input logic [1:0] e_code);
      logic [AW-1:0] e_din;
      @(negedge clk);
      rst = 1'b0;
      {en, op_jmp, op_call, op_ret, cond_ok} = ctl;
      target = tgt;
      e_din = e_pc + 11'd1;
      exp_q.push_back({e_pc, e_v, e_wr, e_rd, e_din, e_dep, e_f, e_code});
      name_q.push_back(nm);
   endtask

   initial begin
      {en, op_jmp, op_call, op_ret, cond_ok} = IDLE;
      target = '0;

      // Reset values, then free-running count with wrap.
      do_reset();
      cyc("rst_state", IDLE, 11'h000, 11'h000, 1, 0, 0, 4'd0, 0, 2'b00);
      for (int i = 0; i < 2050; i++)
         cyc("seq_count", NOP, 11'h000, AW'(i), 1, 0, 0, 4'd0, 0, 2'b00);

      // Call/return round trip, cond_ok=0 jump, stall.
      do_reset();
      cyc("jmp_010",     JMP,    11'h010, 11'h000, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("call_push",   CALL,   11'h200, 11'h010, 1, 1, 0, 4'd0, 0, 2'b00);
      cyc("ret_pop",     RET,    11'h000, 11'h200, 1, 0, 1, 4'd1, 0, 2'b00);
      cyc("ret_bubble",  CR,     11'h3AA, 11'h200, 0, 0, 0, 4'd0, 0, 2'b00);
      cyc("ret_addr",    NOP,    11'h000, 11'h011, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("jmp_nocond",  JMP_NC, 11'h300, 11'h012, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("after_nc",    NOP,    11'h000, 11'h013, 1, 0, 0, 4'd0, 0, 2'b00);
      for (int i = 0; i < 5; i++)
         cyc("stall_call", STALLC, 11'h100, 11'h014, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("stall_end",   NOP,    11'h000, 11'h014, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("resume",      NOP,    11'h000, 11'h015, 1, 0, 0, 4'd0, 0, 2'b00);

      // Priority, back-to-back ret, underflow fault.
      do_reset();
      cyc("p_call1",     CALL,   11'h100, 11'h000, 1, 1, 0, 4'd0, 0, 2'b00);
      cyc("p_call2",     CALL,   11'h200, 11'h100, 1, 1, 0, 4'd1, 0, 2'b00);
      cyc("p_all3",      ALL3,   11'h555, 11'h200, 1, 0, 1, 4'd2, 0, 2'b00);
      cyc("p_ret_ign",   RET,    11'h000, 11'h200, 0, 0, 0, 4'd1, 0, 2'b00);
      cyc("p_call_jmp",  CJ,     11'h300, 11'h101, 1, 1, 0, 4'd1, 0, 2'b00);
      cyc("p_at_300",    NOP,    11'h000, 11'h300, 1, 0, 0, 4'd2, 0, 2'b00);
      cyc("p_ret2",      RET,    11'h000, 11'h301, 1, 0, 1, 4'd2, 0, 2'b00);
      cyc("p_ret2_ign",  RET,    11'h000, 11'h301, 0, 0, 0, 4'd1, 0, 2'b00);
      cyc("p_ret_102",   NOP,    11'h000, 11'h102, 1, 0, 0, 4'd1, 0, 2'b00);
      cyc("p_ret3",      RET,    11'h000, 11'h103, 1, 0, 1, 4'd1, 0, 2'b00);
      cyc("p_bubble3",   NOP,    11'h000, 11'h103, 0, 0, 0, 4'd0, 0, 2'b00);
      cyc("p_ret_001",   NOP,    11'h000, 11'h001, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("unf_ret",     RET,    11'h000, 11'h002, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("unf_fault",   CJ,     11'h300, 11'h002, 0, 0, 0, 4'd0, 1, 2'b10);
      cyc("unf_hold",    RET,    11'h000, 11'h002, 0, 0, 0, 4'd0, 1, 2'b10);
      do_reset();
      cyc("rst_unf",     IDLE,   11'h000, 11'h000, 1, 0, 0, 4'd0, 0, 2'b00);

      // Nesting to the limit, then overflow.
      for (int k = 0; k < 15; k++)
         cyc("call_nest", CALL, AW'(256 + k), (k == 0) ? 11'h000 : AW'(256 + k - 1),
             1, 1, 0, 4'(k), 0, 2'b00);
      cyc("ovf_call",    CALL,   11'h7AA, 11'h10E, 1, 0, 0, 4'd15, 0, 2'b00);
      cyc("ovf_fault",   JMP,    11'h123, 11'h10E, 0, 0, 0, 4'd15, 1, 2'b01);
      cyc("ovf_hold",    NOP,    11'h000, 11'h10E, 0, 0, 0, 4'd15, 1, 2'b01);
      do_reset();
      cyc("rst_ovf",     IDLE,   11'h000, 11'h000, 1, 0, 0, 4'd0, 0, 2'b00);

      // Call from 0x7FF pushes 0x000; reset during the return bubble.
      cyc("jmp_7ff",     JMP,    11'h7FF, 11'h000, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("call_wrap",   CALL,   11'h050, 11'h7FF, 1, 1, 0, 4'd0, 0, 2'b00);
      cyc("ret_wrap",    RET,    11'h000, 11'h050, 1, 0, 1, 4'd1, 0, 2'b00);
      cyc("wrap_bubble", NOP,    11'h000, 11'h050, 0, 0, 0, 4'd0, 0, 2'b00);
      cyc("wrap_addr",   CALL,   11'h066, 11'h000, 1, 1, 0, 4'd0, 0, 2'b00);
      cyc("ret_mid",     RET,    11'h000, 11'h066, 1, 0, 1, 4'd1, 0, 2'b00);
      do_reset();
      cyc("rst_retload", IDLE,   11'h000, 11'h000, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("final_seq",   NOP,    11'h000, 11'h000, 1, 0, 0, 4'd0, 0, 2'b00);
      cyc("final_seq2",  IDLE,   11'h000, 11'h001, 1, 0, 0, 4'd0, 0, 2'b00);

      repeat (3) @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
